// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge port between the MEM stage and memory.
interface mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// MEM-stage load/store unit: lane alignment, load extension, req/ack stall FSM.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memwrite_m,
    input  logic                memtoreg_m,
    input  logic [31:0]         aluout_m,
    input  logic [31:0]         writedata_m,
    input  logic [31:0]         instr_m,
    output logic                stall_m,
    output logic [31:0]         readdata_m,
    output logic                rd_valid,
    output logic                mem_err,
    output logic                align_err,
    mem_access_if.master        mem
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [29:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          load_q, load_d;
    logic [1:0]    sz_q, sz_d;
    logic          sgn_q, sgn_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rdv_q, rdv_d;
    logic          err_q, err_d;

    logic [5:0]  op;
    logic        memop, is_byte, is_half, is_sgn, misalign;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] rext;
    logic        unused_instr;

    assign op           = instr_m[31:26];
    assign unused_instr = ^instr_m[25:0];
    assign memop        = memwrite_m | memtoreg_m;
    assign is_byte      = (op == 6'h20) || (op == 6'h24) || (op == 6'h28);
    assign is_half      = (op == 6'h21) || (op == 6'h25) || (op == 6'h29);
    assign is_sgn       = (op == 6'h20) || (op == 6'h21);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (is_half & aluout_m[0]) |
                      (~is_byte & ~is_half & (|aluout_m[1:0]));
`else
    assign misalign = 1'b0;
`endif

    // Unrecognised opcodes fall through to a full-word access.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = writedata_m;
        unique case (1'b1)
            is_byte: begin
                be_new    = 4'b0001 << aluout_m[1:0];
                wdata_new = {4{writedata_m[7:0]}};
            end
            is_half: begin
                be_new    = aluout_m[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{writedata_m[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rbyte = mem.mem_rdata[{lane_q, 3'b000} +: 8];
        rhalf = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        unique case (sz_q)
            2'd0:    rext = {{24{sgn_q & rbyte[7]}}, rbyte};
            2'd1:    rext = {{16{sgn_q & rhalf[15]}}, rhalf};
            default: rext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        load_d  = load_q;
        sz_d    = sz_q;
        sgn_d   = sgn_q;
        lane_d  = lane_q;
        rdata_d = rdata_q;
        rdv_d   = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (memop && !misalign) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = memwrite_m;
                    addr_d  = aluout_m[31:2];
                    wdata_d = wdata_new;
                    be_d    = be_new;
                    load_d  = ~memwrite_m;
                    sz_d    = is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
                    sgn_d   = is_sgn;
                    lane_d  = aluout_m[1:0];
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (load_q) begin
                        rdata_d = rext;
                        rdv_d   = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (load_q) begin
                        rdata_d = '0;
                        rdv_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            load_q  <= 1'b0;
            sz_q    <= '0;
            sgn_q   <= 1'b0;
            lane_q  <= '0;
            rdata_q <= '0;
            rdv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            load_q  <= load_d;
            sz_q    <= sz_d;
            sgn_q   <= sgn_d;
            lane_q  <= lane_d;
            rdata_q <= rdata_d;
            rdv_q   <= rdv_d;
            err_q   <= err_d;
        end
    end

    // Detection-cycle stall is combinational so the pipeline freezes at once.
    assign stall_m = ~rst & (((state_q == IDLE) & memop & ~misalign) |
                             (state_q == REQ));
    assign align_err = ~rst & (state_q == IDLE) & memop & misalign;

    assign readdata_m    = rdata_q;
    assign rd_valid      = rdv_q;
    assign mem_err       = err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;
endmodule

// File: tb/tb_mem_access.sv
// Randomised self-checking bench for mem_access against a lane-arithmetic model.
module tb_mem_access;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memwrite_m, memtoreg_m;
    logic [31:0] aluout_m, writedata_m, instr_m;
    logic        stall_m, rd_valid, mem_err, align_err;
    logic [31:0] readdata_m;

    int vec = 0;
    int bad = 0;
    logic [31:0] exp_rd = '0;
    logic        exp_err = 1'b0;

    mem_access_if mif ();

    mem_access #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .memwrite_m(memwrite_m), .memtoreg_m(memtoreg_m),
        .aluout_m(aluout_m), .writedata_m(writedata_m), .instr_m(instr_m),
        .stall_m(stall_m), .readdata_m(readdata_m), .rd_valid(rd_valid),
        .mem_err(mem_err), .align_err(align_err), .mem(mif.master)
    );

    always #5 clk = ~clk;

    function automatic int size_of(input logic [5:0] op);
        if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 1;
        if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] w);
        longint v;
        int sz = size_of(op);
        bit sg = (op == 6'h20 || op == 6'h21);
        if (sz == 1) begin
            v = (w >> (8 * (a % 4))) % 256;
            if (sg && v >= 128) v = v - 256;
        end else if (sz == 2) begin
            v = (w >> (16 * ((a / 2) % 2))) % 65536;
            if (sg && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [31:0] a);
        int sz = size_of(op);
        if (sz == 1) return 4'(1 << (a % 4));
        if (sz == 2) return 4'(3 << (2 * ((a / 2) % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] rt);
        int sz = size_of(op);
        if (sz == 1) return rt[7:0] * 32'h0101_0101;
        if (sz == 2) return rt[15:0] * 32'h0001_0001;
        return rt;
    endfunction

    function automatic bit ref_misalign(input logic [5:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        if (size_of(op) == 2) return (a % 2) != 0;
        if (size_of(op) == 4) return (a % 4) != 0;
`endif
        return 1'b0;
    endfunction

    // Caller is at a negedge with the FSM idle; ack_k = 0 means never ack.
    task automatic access(input string nm, input logic [5:0] op, input logic wr,
                          input logic rd, input logic [31:0] a, input logic [31:0] rt,
                          input int ack_k, input logic [31:0] rdw);
        int  stalls = 0;
        int  reqs = 0;
        bit  done = 0;
        bit  ld = rd & ~wr;
        bit  tmo = (ack_k == 0);
        memwrite_m  = wr;
        memtoreg_m  = rd;
        aluout_m    = a;
        writedata_m = rt;
        instr_m     = {op, 26'($urandom)};
        #1;
        if (ref_misalign(op, a)) begin
            vec++;
            if (align_err !== 1'b1 || stall_m !== 1'b0) begin
                bad++;
                $display("FAIL %s align: align_err=%b stall=%b want 1/0", nm, align_err, stall_m);
            end
            @(negedge clk);
            memwrite_m = 1'b0;
            memtoreg_m = 1'b0;
            #1;
            vec++;
            if (mif.mem_req !== 1'b0 || rd_valid !== 1'b0 || readdata_m !== exp_rd) begin
                bad++;
                $display("FAIL %s align_noacc: req=%b rdv=%b rd=%h want 0/0/%h",
                         nm, mif.mem_req, rd_valid, readdata_m, exp_rd);
            end
            return;
        end
        vec++;
        if (stall_m !== 1'b1 || align_err !== 1'b0) begin
            bad++;
            $display("FAIL %s detect: stall=%b align_err=%b want 1/0", nm, stall_m, align_err);
        end
        if (stall_m === 1'b1) stalls++;
        for (int c = 0; c < TO + 4 && !done; c++) begin
            @(negedge clk);
            mif.mem_ack = 1'b0;
            if (mif.mem_req === 1'b1) begin
                reqs++;
                if (stall_m === 1'b1) stalls++;
                vec++;
                if (mif.mem_we !== wr || mif.mem_addr !== a[31:2] ||
                    (wr && (mif.mem_be !== ref_be(op, a) ||
                            mif.mem_wdata !== ref_wdata(op, rt)))) begin
                    bad++;
                    $display("FAIL %s bus: we=%b addr=%h be=%b wd=%h want %b/%h/%b/%h",
                             nm, mif.mem_we, mif.mem_addr, mif.mem_be, mif.mem_wdata,
                             wr, a[31:2], ref_be(op, a), ref_wdata(op, rt));
                end
                if (reqs == ack_k) begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = rdw;
                end else begin
                    mif.mem_rdata = $urandom;
                end
            end else begin
                done = 1;
            end
        end
        vec++;
        if (!done) begin
            bad++;
            $display("FAIL %s wait: access never completed within %0d cycles", nm, TO + 4);
            return;
        end
        if (ld) exp_rd = tmo ? 32'h0 : ref_load(op, a, rdw);
        if (tmo) exp_err = 1'b1;
        if (stall_m !== 1'b0 || stalls != (tmo ? TO : ack_k) + 1 ||
            rd_valid !== ld || readdata_m !== exp_rd || mem_err !== exp_err) begin
            bad++;
            $display("FAIL %s done: stall=%b stalls=%0d rdv=%b rd=%h err=%b want 0/%0d/%b/%h/%b",
                     nm, stall_m, stalls, rd_valid, readdata_m, mem_err,
                     (tmo ? TO : ack_k) + 1, ld, exp_rd, exp_err);
        end
        @(negedge clk);
        memwrite_m = 1'b0;
        memtoreg_m = 1'b0;
        #1;
        vec++;
        if (rd_valid !== 1'b0 || mif.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s after: rdv=%b req=%b want 0/0", nm, rd_valid, mif.mem_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        memwrite_m = 1'b1;
        memtoreg_m = 1'b0;
        aluout_m = 32'h100;
        writedata_m = '0;
        instr_m = {6'h2B, 26'h0};
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        #1;
        vec++;
        if (stall_m !== 0 || readdata_m !== 0 || rd_valid !== 0 || mem_err !== 0 ||
            align_err !== 0 || mif.mem_req !== 0 || mif.mem_we !== 0 ||
            mif.mem_addr !== 0 || mif.mem_be !== 0 || mif.mem_wdata !== 0) begin
            bad++;
            $display("FAIL reset: stall=%b rd=%h rdv=%b err=%b req=%b be=%b want all 0",
                     stall_m, readdata_m, rd_valid, mem_err, mif.mem_req, mif.mem_be);
        end
        memwrite_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_rd = '0;
        exp_err = 1'b0;
    endtask

    task automatic test_lw();
        access("lw_basic", 6'h23, 0, 1, 32'h100, 32'h0, 3, 32'hCAFE_BABE);
    endtask

    task automatic test_load_ext();
        access("lb", 6'h20, 0, 1, 32'h103, 32'h0, 1, 32'h80FF_FFFF);
        access("lbu", 6'h24, 0, 1, 32'h103, 32'h0, 2, 32'h80FF_FFFF);
        access("lhu", 6'h25, 0, 1, 32'h102, 32'h0, 1, 32'h80FF_FFFF);
        access("lh", 6'h21, 0, 1, 32'h102, 32'h0, 1, 32'h80FF_FFFF);
    endtask

    task automatic test_store();
        access("sb", 6'h28, 1, 0, 32'h201, 32'h1234_5678, 1, 32'h0);
        access("sh", 6'h29, 1, 0, 32'h202, 32'hAAAA_BEEF, 2, 32'h0);
        access("sw", 6'h2B, 1, 0, 32'h204, 32'hDEAD_0001, 1, 32'h0);
        access("st_and_ld", 6'h2B, 1, 1, 32'h208, 32'h0BAD_F00D, 1, 32'h1111_1111);
    endtask

    task automatic test_timeout();
        access("timeout_lw", 6'h23, 0, 1, 32'h300, 32'h0, 0, 32'h0);
        access("after_tmo", 6'h23, 0, 1, 32'h304, 32'h0, 1, 32'h5555_AAAA);
    endtask

    task automatic test_reset_mid();
        memtoreg_m = 1'b1;
        memwrite_m = 1'b0;
        aluout_m = 32'h400;
        instr_m = {6'h23, 26'h0};
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if (mif.mem_req !== 1'b0 || stall_m !== 1'b0 || mem_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: req=%b stall=%b err=%b want 0/0/0",
                     mif.mem_req, stall_m, mem_err);
        end
        @(negedge clk);
        memtoreg_m = 1'b0;
        rst = 1'b0;
        exp_rd = '0;
        exp_err = 1'b0;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mif.mem_ack = 1'b0;
        #1;
        vec++;
        if (mif.mem_req !== 1'b0 || rd_valid !== 1'b0 || readdata_m !== 32'h0) begin
            bad++;
            $display("FAIL late_ack: req=%b rdv=%b rd=%h want 0/0/0",
                     mif.mem_req, rd_valid, readdata_m);
        end
        access("lw_post_rst", 6'h23, 0, 1, 32'h404, 32'h0, 1, 32'h1357_9BDF);
    endtask

    task automatic test_misalign();
        access("lw_0x102", 6'h23, 0, 1, 32'h102, 32'h0, 1, 32'h7654_3210);
        access("sh_0x203", 6'h29, 1, 0, 32'h203, 32'h0000_ABCD, 1, 32'h0);
    endtask

    task automatic test_back_to_back();
        access("b2b_0", 6'h23, 0, 1, 32'h500, 32'h0, 1, 32'h0000_0001);
        access("b2b_1", 6'h23, 0, 1, 32'h500, 32'h0, 1, 32'h0000_0002);
    endtask

    task automatic test_random();
        logic [5:0] ops[9] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23,
                               6'h28, 6'h29, 6'h2B, 6'h0F};
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  op = ops[$urandom_range(0, 8)];
            logic        wr = (op[3] == 1'b1 && op != 6'h0F) ? 1'b1 : 1'(($urandom % 4) == 0);
            logic        rd = wr ? 1'($urandom) : 1'b1;
            int          k  = $urandom_range(0, TO);
            access("random", op, wr, rd, $urandom, $urandom, k, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_timeout();
        test_reset_mid();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
